// File: rtl/rand_point_gen_if.sv
// rtl/rand_point_gen_if.sv - request/point handshake bundle between game control and rand_point_gen
interface rand_point_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           req;
  logic [X_W-1:0] excl_x;
  logic [Y_W-1:0] excl_y;
  logic [X_W-1:0] randX;
  logic [Y_W-1:0] randY;
  logic           valid;
  logic           busy;
  logic           fallback;

  modport master (
    output req, excl_x, excl_y,
    input  randX, randY, valid, busy, fallback
  );

  modport slave (
    input  req, excl_x, excl_y,
    output randX, randY, valid, busy, fallback
  );
endinterface

// File: rtl/rand_point_gen.sv
// rtl/rand_point_gen.sv - grid-aligned pseudo-random point generator with exclusion and bounded latency
// Optional RAND_POINT_SEED_LOAD_EN adds seed_load/seed_in for runtime LFSR reseeding.
module rand_point_gen #(
  parameter int               X_W       = 10,
  parameter int               Y_W       = 9,
  parameter int               GRID      = 10,
  parameter int               X_CELLS   = 62,
  parameter int               Y_CELLS   = 46,
  parameter int               LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int               MAX_TRIES = 15
) (
  input  logic              VGA_clk,
  input  logic              rst_n,
`ifdef RAND_POINT_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
`endif
  rand_point_gen_if.slave   pt
);

  localparam int CXW = $clog2(X_CELLS);
  localparam int CYW = $clog2(Y_CELLS);
  localparam int CXE = (CXW > 0) ? CXW : 1;
  localparam int CYE = (CYW > 0) ? CYW : 1;
  localparam int TW  = $clog2(MAX_TRIES + 1);

  // Right-shifting Galois masks giving maximal-length sequences
  function automatic logic [31:0] galois_taps(input int w);
    case (w)
      3:       galois_taps = 32'h0000_0006;
      4:       galois_taps = 32'h0000_000C;
      5:       galois_taps = 32'h0000_0014;
      6:       galois_taps = 32'h0000_0030;
      7:       galois_taps = 32'h0000_0060;
      8:       galois_taps = 32'h0000_00B8;
      9:       galois_taps = 32'h0000_0110;
      10:      galois_taps = 32'h0000_0240;
      11:      galois_taps = 32'h0000_0500;
      12:      galois_taps = 32'h0000_0E08;
      13:      galois_taps = 32'h0000_1C80;
      14:      galois_taps = 32'h0000_3802;
      15:      galois_taps = 32'h0000_6000;
      16:      galois_taps = 32'h0000_B400;
      17:      galois_taps = 32'h0001_2000;
      18:      galois_taps = 32'h0002_0400;
      19:      galois_taps = 32'h0007_2000;
      20:      galois_taps = 32'h0009_0000;
      21:      galois_taps = 32'h0014_0000;
      22:      galois_taps = 32'h0030_0000;
      23:      galois_taps = 32'h0042_0000;
      24:      galois_taps = 32'h00E1_0000;
      25:      galois_taps = 32'h0120_0000;
      26:      galois_taps = 32'h0200_0023;
      27:      galois_taps = 32'h0400_0013;
      28:      galois_taps = 32'h0900_0000;
      29:      galois_taps = 32'h1400_0000;
      30:      galois_taps = 32'h2000_0029;
      31:      galois_taps = 32'h4800_0000;
      32:      galois_taps = 32'h8020_0003;
      default: galois_taps = 32'h0000_B400;
    endcase
  endfunction

  localparam logic [31:0]       TAPS_ALL = galois_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAW     = 2'd1,
    FALLBACK = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [CXE-1:0]    sx_q, sx_d, sx_inc;
  logic [CYE-1:0]    sy_q, sy_d;
  logic [TW-1:0]     tries_q, tries_d, tries_inc;
  logic [X_W-1:0]    exx_q, exx_d;
  logic [Y_W-1:0]    exy_q, exy_d;
  logic [X_W-1:0]    randx_q, randx_d;
  logic [Y_W-1:0]    randy_q, randy_d;
  logic              valid_q, valid_d;
  logic              fallback_q, fallback_d;

  logic [CXE-1:0]    cx;
  logic [CYE-1:0]    cy;
  logic [X_W-1:0]    cand_px, fb_px0, fb_px1, fb_px;
  logic [Y_W-1:0]    cand_py, fb_py;
  logic              cand_ok;

  // Degenerate single-row/column grids have no LFSR bits for that axis
  generate
    if (CXW > 0) begin : g_cx
      assign cx = lfsr_q[CXW-1:0];
    end else begin : g_cx0
      assign cx = '0;
    end
    if (CYW > 0) begin : g_cy
      assign cy = lfsr_q[CXW+CYW-1:CXW];
    end else begin : g_cy0
      assign cy = '0;
    end
  endgenerate

  assign lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

  assign cand_px = X_W'(int'(cx) * GRID);
  assign cand_py = Y_W'(int'(cy) * GRID);
  assign cand_ok = (int'(cx) < X_CELLS) && (int'(cy) < Y_CELLS) &&
                   !((cand_px == exx_q) && (cand_py == exy_q));

  assign sx_inc  = (int'(sx_q) == X_CELLS - 1) ? '0 : sx_q + 1'b1;
  assign fb_px0  = X_W'(int'(sx_q) * GRID);
  assign fb_px1  = X_W'(int'(sx_inc) * GRID);
  assign fb_py   = Y_W'(int'(sy_q) * GRID);
  // A single-cell grid can still collide after the nudge; the point is emitted anyway
  assign fb_px   = ((fb_px0 == exx_q) && (fb_py == exy_q)) ? fb_px1 : fb_px0;

  assign tries_inc = tries_q + 1'b1;

  always_comb begin
    lfsr_d = lfsr_step;
`ifdef RAND_POINT_SEED_LOAD_EN
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end
`endif
    sx_d = sx_inc;
    sy_d = (sy_q == '0) ? CYE'(Y_CELLS - 1) : sy_q - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    exx_d      = exx_q;
    exy_d      = exy_q;
    randx_d    = randx_q;
    randy_d    = randy_q;
    valid_d    = 1'b0;
    fallback_d = fallback_q;
    case (state_q)
      IDLE: begin
        if (pt.req) begin
          exx_d   = pt.excl_x;
          exy_d   = pt.excl_y;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          randx_d    = cand_px;
          randy_d    = cand_py;
          valid_d    = 1'b1;
          fallback_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == TW'(MAX_TRIES)) begin
            state_d = FALLBACK;
          end
        end
      end
      FALLBACK: begin
        randx_d    = fb_px;
        randy_d    = fb_py;
        valid_d    = 1'b1;
        fallback_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      sx_q       <= '0;
      sy_q       <= CYE'(Y_CELLS - 1);
      tries_q    <= '0;
      exx_q      <= '0;
      exy_q      <= '0;
      randx_q    <= '0;
      randy_q    <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      tries_q    <= tries_d;
      exx_q      <= exx_d;
      exy_q      <= exy_d;
      randx_q    <= randx_d;
      randy_q    <= randy_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
    end
  end

  assign pt.randX    = randx_q;
  assign pt.randY    = randy_q;
  assign pt.valid    = valid_q;
  assign pt.busy     = (state_q != IDLE);
  assign pt.fallback = fallback_q;

endmodule

// File: tb/tb_rand_point_gen.sv
// tb/tb_rand_point_gen.sv - directed bench for rand_point_gen on default, 1x2 and 1x1 grids
module tb_rand_point_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;
  logic [18:0] seqs [3][6];

  rand_point_gen_if if_a ();
  rand_point_gen_if if_b ();
  rand_point_gen_if if_c ();

  rand_point_gen u_a (
    .VGA_clk(clk), .rst_n(rst_n),
`ifdef RAND_POINT_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .pt(if_a)
  );

  rand_point_gen #(.X_CELLS(1), .Y_CELLS(2)) u_b (
    .VGA_clk(clk), .rst_n(rst_n),
`ifdef RAND_POINT_SEED_LOAD_EN
    .seed_load(1'b0), .seed_in(16'h0000),
`endif
    .pt(if_b)
  );

  rand_point_gen #(.X_CELLS(1), .Y_CELLS(1)) u_c (
    .VGA_clk(clk), .rst_n(rst_n),
`ifdef RAND_POINT_SEED_LOAD_EN
    .seed_load(1'b0), .seed_in(16'h0000),
`endif
    .pt(if_c)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Independent model of the 16-bit Galois sequence shared by all three instances
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
`ifdef RAND_POINT_SEED_LOAD_EN
    else if (seed_load) m_lfsr <= (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
`endif
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({if_a.randX, if_a.randY, if_a.valid, if_a.busy, if_a.fallback} !== 22'd0) begin errors++; $display("FAIL reset_a: got %h required 0", {if_a.randX, if_a.randY, if_a.valid, if_a.busy, if_a.fallback}); end
    checks++; if ({if_b.randX, if_b.randY, if_b.valid, if_b.busy, if_b.fallback} !== 22'd0) begin errors++; $display("FAIL reset_b: got %h required 0", {if_b.randX, if_b.randY, if_b.valid, if_b.busy, if_b.fallback}); end
    checks++; if ({if_c.randX, if_c.randY, if_c.valid, if_c.busy, if_c.fallback} !== 22'd0) begin errors++; $display("FAIL reset_c: got %h required 0", {if_c.randX, if_c.randY, if_c.valid, if_c.busy, if_c.fallback}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if ({if_a.randX, if_a.randY, if_a.valid, if_a.busy, if_a.fallback} !== 22'd0) begin errors++; $display("FAIL idle_a: got %h required 0", {if_a.randX, if_a.randY, if_a.valid, if_a.busy, if_a.fallback}); end
    checks++; if ({if_b.randX, if_b.randY, if_b.valid, if_b.busy, if_b.fallback} !== 22'd0) begin errors++; $display("FAIL idle_b: got %h required 0", {if_b.randX, if_b.randY, if_b.valid, if_b.busy, if_b.fallback}); end
    checks++; if ({if_c.randX, if_c.randY, if_c.valid, if_c.busy, if_c.fallback} !== 22'd0) begin errors++; $display("FAIL idle_c: got %h required 0", {if_c.randX, if_c.randY, if_c.valid, if_c.busy, if_c.fallback}); end
  endtask

  task automatic req_a(input logic [9:0] ex, input logic [8:0] ey, output logic [9:0] ox, output logic [8:0] oy);
    logic [9:0] px;
    logic [8:0] py;
    logic [5:0] cx, cy;
    int pk, ptries, lat;
    px = '0; py = '0; pk = 0; ptries = 0; lat = 0;
    if_a.req = 1'b1; if_a.excl_x = ex; if_a.excl_y = ey;
    @(posedge clk); @(negedge clk);
    if_a.req = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (pk == 0 && ptries < 15) begin
        cx = m_lfsr[5:0]; cy = m_lfsr[11:6];
        if (cx < 6'd62 && cy < 6'd46 && !((10'(cx) * 10'd10 == ex) && (9'(cy) * 9'd10 == ey))) begin
          pk = k; px = 10'(cx) * 10'd10; py = 9'(cy) * 9'd10;
        end else ptries++;
      end
      @(posedge clk); @(negedge clk);
      if (if_a.valid) lat = k + 1;
    end
    ox = if_a.randX; oy = if_a.randY;
    checks++;
    if (lat == 0) begin
      errors++; $display("FAIL a_timeout: no valid in 20 cycles, required latency 2..17");
    end else begin
      checks++;
      if (pk != 0) begin
        if (lat != pk + 1 || ox !== px || oy !== py || if_a.fallback !== 1'b0) begin
          errors++; $display("FAIL a_point: got lat=%0d (%0d,%0d) fb=%b required lat=%0d (%0d,%0d) fb=0", lat, ox, oy, if_a.fallback, pk + 1, px, py);
        end
      end else if (lat != 17 || if_a.fallback !== 1'b1) begin
        errors++; $display("FAIL a_fallback: got lat=%0d fb=%b required lat=17 fb=1", lat, if_a.fallback);
      end
      checks++;
      if (ox % 10 != 0 || ox > 10'd610 || oy % 10 != 0 || oy > 9'd450) begin
        errors++; $display("FAIL a_bounds: got (%0d,%0d) required grid multiple within (610,450)", ox, oy);
      end
      checks++;
      if (ox == ex && oy == ey) begin errors++; $display("FAIL a_excl: got (%0d,%0d) required not (%0d,%0d)", ox, oy, ex, ey); end
      checks++;
      if (if_a.busy !== 1'b0) begin errors++; $display("FAIL a_busy: got %b required 0", if_a.busy); end
    end
    @(negedge clk);
    checks++;
    if (if_a.valid !== 1'b0) begin errors++; $display("FAIL a_pulse: got valid=%b required 0", if_a.valid); end
  endtask

  task automatic test_random_points();
    logic [15:0] nl;
    logic [9:0]  ex, ox;
    logic [8:0]  ey, oy;
    for (int i = 0; i < 1000; i++) begin
      ex = '0; ey = '0;
      // Every fourth request excludes exactly the first candidate, forcing a reject
      if (i % 4 == 3) begin
        nl = lfsr_step(m_lfsr);
        ex = 10'(nl[5:0]) * 10'd10;
        ey = 9'(nl[11:6]) * 9'd10;
      end
      req_a(ex, ey, ox, oy);
      repeat (i % 3) @(negedge clk);
    end
  endtask

  task automatic req_b(input logic [8:0] ey);
    int pk, ptries, lat;
    logic [8:0] py;
    pk = 0; ptries = 0; lat = 0; py = '0;
    if_b.req = 1'b1; if_b.excl_x = '0; if_b.excl_y = ey;
    @(posedge clk); @(negedge clk);
    if_b.req = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (pk == 0 && ptries < 15) begin
        if ((m_lfsr[0] ? 9'd10 : 9'd0) != ey) begin pk = k; py = m_lfsr[0] ? 9'd10 : 9'd0; end
        else ptries++;
      end
      @(posedge clk); @(negedge clk);
      if (if_b.valid) lat = k + 1;
    end
    checks++;
    if (lat == 0) begin
      errors++; $display("FAIL b_timeout: no valid in 20 cycles, required latency 2..17");
    end else if (pk != 0) begin
      checks++;
      if (lat != pk + 1 || if_b.randX !== 10'd0 || if_b.randY !== py || if_b.fallback !== 1'b0) begin
        errors++; $display("FAIL b_point: got lat=%0d (%0d,%0d) fb=%b required lat=%0d (0,%0d) fb=0", lat, if_b.randX, if_b.randY, if_b.fallback, pk + 1, py);
      end
    end else begin
      checks++;
      if (lat != 17 || if_b.randX !== 10'd0 || (if_b.randY !== 9'd0 && if_b.randY !== 9'd10) || if_b.fallback !== 1'b1) begin
        errors++; $display("FAIL b_fallback: got lat=%0d (%0d,%0d) fb=%b required lat=17 x=0 fb=1", lat, if_b.randX, if_b.randY, if_b.fallback);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_two_cell();
    for (int i = 0; i < 40; i++) begin
      req_b(9'd0);
      repeat (i % 2) @(negedge clk);
    end
    for (int i = 0; i < 10; i++) req_b(9'd10);
  endtask

  task automatic req_c(input logic [9:0] ex, input logic [8:0] ey, input int exp_lat, input logic exp_fb);
    int lat;
    logic busy_ok;
    lat = 0; busy_ok = 1'b1;
    if_c.req = 1'b1; if_c.excl_x = ex; if_c.excl_y = ey;
    @(posedge clk); @(negedge clk);
    if_c.req = 1'b0;
    for (int k = 1; k <= 25 && lat == 0; k++) begin
      if (if_c.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); @(negedge clk);
      if (if_c.valid) lat = k + 1;
    end
    checks++;
    if (lat != exp_lat || if_c.fallback !== exp_fb || if_c.randX !== 10'd0 || if_c.randY !== 9'd0) begin
      errors++; $display("FAIL c_point: got lat=%0d (%0d,%0d) fb=%b required lat=%0d (0,0) fb=%b", lat, if_c.randX, if_c.randY, if_c.fallback, exp_lat, exp_fb);
    end
    checks++;
    if (!busy_ok || if_c.busy !== 1'b0) begin errors++; $display("FAIL c_busy: got busy_ok=%b busy_end=%b required 1/0", busy_ok, if_c.busy); end
    @(negedge clk);
  endtask

  task automatic test_single_cell();
    req_c(10'd0, 9'd0, 17, 1'b1);
    req_c(10'd5, 9'd0, 2, 1'b0);
    req_c(10'd0, 9'd0, 17, 1'b1);
    req_c(10'd0, 9'd3, 2, 1'b0);
  endtask

  task automatic test_busy_ignore();
    int nval, first;
    nval = 0; first = 0;
    if_c.req = 1'b1; if_c.excl_x = '0; if_c.excl_y = '0;
    @(posedge clk); @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      if_c.req = (k == 3 || k == 10);
      @(posedge clk); @(negedge clk);
      if (if_c.valid) begin nval++; if (first == 0) first = k + 1; end
    end
    if_c.req = 1'b0;
    checks++;
    if (nval != 1 || first != 17) begin errors++; $display("FAIL busy_ignore: got %0d valids first lat=%0d required 1 at 17", nval, first); end
  endtask

  task automatic test_back_to_back();
    int nval;
    nval = 0;
    if_c.req = 1'b1; if_c.excl_x = 10'd5; if_c.excl_y = '0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (if_c.valid) nval++;
    end
    if_c.req = 1'b0;
    checks++;
    if (nval != 10) begin errors++; $display("FAIL back_to_back: got %0d valids required 10", nval); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_draw();
    int nval;
    nval = 0;
    if_c.req = 1'b1; if_c.excl_x = '0; if_c.excl_y = '0;
    @(posedge clk); @(negedge clk);
    if_c.req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (if_c.busy !== 1'b1) begin errors++; $display("FAIL draw_busy: got %b required 1", if_c.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_c.busy !== 1'b0 || if_c.valid !== 1'b0) begin errors++; $display("FAIL rst_draw: got busy=%b valid=%b required 0/0", if_c.busy, if_c.valid); end
    checks++;
    if (if_a.randX !== 10'd0 || if_a.randY !== 9'd0) begin errors++; $display("FAIL rst_point: got (%0d,%0d) required (0,0)", if_a.randX, if_a.randY); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (if_c.valid) nval++;
    end
    checks++;
    if (nval != 0) begin errors++; $display("FAIL rst_no_valid: got %0d valids required 0", nval); end
  endtask

`ifdef RAND_POINT_SEED_LOAD_EN
  task automatic run_seq(input logic do_load, input logic [15:0] s, input int slot);
    logic [9:0] ox;
    logic [8:0] oy;
    if (do_load) begin
      seed_load = 1'b1; seed_in = s;
      @(posedge clk); @(negedge clk);
      seed_load = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      repeat (i) @(negedge clk);
      req_a(10'd0, 9'd0, ox, oy);
      seqs[slot][i] = {ox, oy};
    end
  endtask

  task automatic test_seed_load();
    run_seq(1'b1, 16'h1234, 0);
    run_seq(1'b1, 16'h1234, 1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seqs[1][i] !== seqs[0][i]) begin errors++; $display("FAIL seed_repeat[%0d]: got %h required %h", i, seqs[1][i], seqs[0][i]); end
    end
    run_seq(1'b1, 16'h0000, 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, 16'h0000, 0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seqs[2][i] !== seqs[0][i]) begin errors++; $display("FAIL seed_zero[%0d]: got %h required %h", i, seqs[2][i], seqs[0][i]); end
    end
  endtask
`endif

  initial begin
    if_a.req = 1'b0; if_a.excl_x = '0; if_a.excl_y = '0;
    if_b.req = 1'b0; if_b.excl_x = '0; if_b.excl_y = '0;
    if_c.req = 1'b0; if_c.excl_x = '0; if_c.excl_y = '0;
    test_reset();
    test_random_points();
    test_two_cell();
    test_single_cell();
    test_busy_ignore();
    test_back_to_back();
    test_reset_in_draw();
`ifdef RAND_POINT_SEED_LOAD_EN
    test_seed_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
